// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG scan register driving a data-mux override: shift/capture/update chain plus a
// settle timer so the registered mux select only rises after the override data is stable.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
    parameter int WIDTH  = 19,
    parameter int SETTLE = 2
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLING = 2'd1,
        S_ACTIVE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [WIDTH:0]   r_sr;
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_select;

    logic [WIDTH:0]   w_sr_nxt;
    state_t           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_select_nxt;
    logic             w_upd;
    logic             w_req;

    // Update decisions use the pre-edge SR, even when the same edge captures or shifts.
    assign w_upd = ijtag_sel & ijtag_ue;
    assign w_req = r_sr[WIDTH];

    always_comb begin
        w_sr_nxt = r_sr;
        if (ijtag_sel && ijtag_ce) begin
            w_sr_nxt = {r_select, functional_data_in};
        end else if (ijtag_sel && ijtag_se) begin
            w_sr_nxt = {ijtag_si, r_sr[WIDTH:1]};
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_sr     <= '0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_select <= 1'b0;
        end else begin
            r_sr     <= w_sr_nxt;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_select <= w_select_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_upd && w_req) begin
                    w_state_nxt = S_SETTLING;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_SETTLING: begin
                if (w_upd) begin
                    if (w_req) begin
                        w_cnt_nxt = CNT_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACTIVE: begin
                if (w_upd && !w_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Select is high exactly while the next state is ACTIVE, so it is flopped with no gap.
    always_comb begin
        w_data_nxt   = r_data;
        w_select_nxt = (w_state_nxt == S_ACTIVE);
        if (w_upd) begin
            w_data_nxt = r_sr[WIDTH-1:0];
        end
    end

    assign ijtag_so       = r_sr[0];
    assign ijtag_data_out = r_data;
    assign ijtag_select   = r_select;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Randomized and directed bench for the scan-controlled mux override, with a queue scoreboard.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

    localparam int W      = 19;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
    logic         so;
    logic [W-1:0] fdi = '0;
    logic [W-1:0] dout;
    logic         dsel;

    firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_data_out     (dout),
        .ijtag_select       (dsel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         so;
        logic [W-1:0] data;
        logic         sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the scan register contents, the override value, and the edge at
    // which the select was last armed; the select is high once SETTLE edges have elapsed.
    logic [W:0]   m_sr = '0;
    logic [W-1:0] m_data = '0;
    bit           m_armed = 1'b0;
    int           m_arm_edge = 0;
    int           m_edge = 0;

    function automatic bit mdl_sel(input int at);
        return m_armed && ((at - m_arm_edge) >= SETTLE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("so", {31'd0, so}, {31'd0, e.so});
            chk("data_out", {13'd0, dout}, {13'd0, e.data});
            chk("select", {31'd0, dsel}, {31'd0, e.sel});
        end
    end

    // Drives one cycle of inputs, predicts the post-edge outputs, then returns just after
    // the following falling edge, when those outputs are stable and already scored.
    task automatic step(input bit s, input bit c, input bit sh, input bit u, input bit d,
                        input logic [W-1:0] f);
        bit         pre_sel;
        logic [W:0] old;
        sel = s; ce = c; se = sh; ue = u; si = d; fdi = f;
        pre_sel = mdl_sel(m_edge);
        old = m_sr;
        m_edge++;
        if (s && u) begin
            m_data = old[W-1:0];
            if (old[W]) begin
                if (!pre_sel) begin
                    m_armed = 1'b1;
                    m_arm_edge = m_edge;
                end
            end else begin
                m_armed = 1'b0;
            end
        end
        if (s && c) m_sr = {pre_sel, f};
        else if (s && sh) m_sr = {d, old[W:1]};
        exp_q.push_back({m_sr[0], m_data, mdl_sel(m_edge)});
        @(negedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [W:0] v);
        for (int i = 0; i <= W; i++) step(1, 0, 1, 0, v[i], W'($urandom));
    endtask

    task automatic update();
        step(1, 0, 0, 1, 0, W'($urandom));
    endtask

    task automatic idle();
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
    endtask

    task automatic rst_pulse(input bit do_chk);
        rst_n = 1'b0;
        #1;
        if (do_chk) begin
            chk("rst_select", {31'd0, dsel}, 32'd0);
            chk("rst_data", {13'd0, dout}, 32'd0);
            chk("rst_so", {31'd0, so}, 32'd0);
        end
        rst_n = 1'b1;
        m_sr = '0;
        m_data = '0;
        m_armed = 1'b0;
    endtask

    initial begin
        logic [W:0] stream;

        #7;
        chk("reset_select", {31'd0, dsel}, 32'd0);
        chk("reset_data", {13'd0, dout}, 32'd0);
        chk("reset_so", {31'd0, so}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Scan-and-arm
        shift_in({1'b1, 19'h5A5A5});
        update();
        chk("arm_data", {13'd0, dout}, 32'h5A5A5);
        chk("arm_sel_u0", {31'd0, dsel}, 32'd0);
        idle();
        chk("arm_sel_u1", {31'd0, dsel}, 32'd0);
        idle();
        chk("arm_sel_u2", {31'd0, dsel}, 32'd1);

        // Live data change while active
        shift_in({1'b1, 19'h00001});
        update();
        chk("live_data", {13'd0, dout}, 32'h00001);
        chk("live_sel", {31'd0, dsel}, 32'd1);

        // Release
        shift_in({1'b0, 19'h12345});
        update();
        chk("rel_sel", {31'd0, dsel}, 32'd0);
        chk("rel_data", {13'd0, dout}, 32'h12345);

        // Capture readback with select high
        shift_in({1'b1, 19'h00000});
        update();
        idle();
        idle();
        chk("cap_pre_sel", {31'd0, dsel}, 32'd1);
        step(1, 1, 1, 0, 0, 19'h7FFFF);
        stream[0] = so;
        for (int i = 1; i <= W; i++) begin
            step(1, 0, 1, 0, 0, W'($urandom));
            stream[i] = so;
        end
        chk("cap_stream", {12'd0, stream}, 32'hFFFFF);

        // Abort: update with req=1, then req=0 on the next edge
        shift_in({1'b0, 19'h00000});
        update();
        shift_in({1'b1, 19'h0ABCD});
        step(1, 0, 1, 1, 0, W'($urandom));
        chk("abort_sel0", {31'd0, dsel}, 32'd0);
        update();
        chk("abort_sel1", {31'd0, dsel}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("abort_sel_hold", {31'd0, dsel}, 32'd0);
        end

        // Asynchronous reset while settling
        shift_in({1'b1, 19'h0ABCD});
        update();
        chk("mid_sel", {31'd0, dsel}, 32'd0);
        rst_pulse(1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_sel", {31'd0, dsel}, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_pulse(0);
            end
            step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
                 $urandom_range(0, 5) == 0, 1'($urandom), W'($urandom));
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl_w19.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl_w19

Interface
REQ-001 Parameter WIDTH, default 19: width of the data path the block controls.
REQ-002 Parameter SETTLE, default 2, legal range 1..15: cycles from data update to select assertion.
REQ-003 One clock; reset is asynchronous and active-low. The clock port is ijtag_tck and the reset port is ijtag_reset.
REQ-004 ijtag_tck  in  1  clock; all state changes on the rising edge.
REQ-005 ijtag_reset  in  1  async active-low reset.
REQ-006 ijtag_sel  in  1  selects this register for capture, shift and update.
REQ-007 ijtag_ce  in  1  capture enable.
REQ-008 ijtag_se  in  1  shift enable.
REQ-009 ijtag_ue  in  1  update enable.
REQ-010 ijtag_si  in  1  scan in.
REQ-011 ijtag_so  out  1  scan out; equals shift-register bit 0.
REQ-012 functional_data_in  in  WIDTH  functional value, captured for observation.
REQ-013 ijtag_data_out  out  WIDTH  override data driven to the mux ijtag_data_in.
REQ-014 ijtag_select  out  1  registered mux select to the mux ijtag_select.

Function
REQ-015 The shift register SR SHALL be WIDTH+1 bits: SR[WIDTH] = select request, SR[WIDTH-1:0] = data.
REQ-016 Capture: when sel&ce, SR SHALL load {ijtag_select, functional_data_in}.
REQ-017 Shift: when sel&se&!ce, SR SHALL shift right: SR[WIDTH] <= si, SR[i] <= SR[i+1].
REQ-018 When ce and se are both high, capture SHALL take priority. With sel low, SR SHALL hold.
REQ-019 Update: when sel&ue, the controller SHALL act on the SR value present before that edge, including when the same edge also captures or shifts.
REQ-020 The FSM SHALL have three states: IDLE, SETTLING and ACTIVE. A 4-bit down-counter cnt SHALL run in SETTLING.
REQ-021 IDLE, update with req=1: ijtag_data_out <= SR data; cnt <= SETTLE-1; go to SETTLING. ijtag_select SHALL stay 0.
REQ-022 IDLE, update with req=0: ijtag_data_out <= SR data; stay in IDLE.
REQ-023 SETTLING, no update: if cnt==0, go to ACTIVE and set ijtag_select <= 1; otherwise decrement cnt.
REQ-024 As a result, ijtag_select SHALL rise exactly SETTLE edges after the update edge. Example: SETTLE=2 gives a rise at update edge+2.
REQ-025 SETTLING, update with req=1: ijtag_data_out SHALL be reloaded and cnt SHALL restart at SETTLE-1.
REQ-026 SETTLING, update with req=0: return to IDLE; ijtag_data_out SHALL be reloaded; ijtag_select SHALL never have pulsed.
REQ-027 ACTIVE, update with req=1: ijtag_data_out SHALL be reloaded and the FSM SHALL stay in ACTIVE with ijtag_select=1 continuously.
REQ-028 ACTIVE, update with req=0: ijtag_select <= 0 and ijtag_data_out <= SR data on the same edge; go to IDLE.
REQ-029 ijtag_select SHALL change only on the transitions defined above and SHALL be glitch-free, driven directly from a flop.
REQ-030 Undefined FSM encodings SHALL recover to IDLE with ijtag_select=0 on the next edge.

Reset
REQ-031 While ijtag_reset=0, the following SHALL hold asynchronously: SR=0, ijtag_data_out=0, ijtag_select=0, cnt=0, state=IDLE, ijtag_so=0.
REQ-032 Reset asserted during SETTLING or ACTIVE SHALL drop ijtag_select immediately. No pending assertion SHALL survive deassertion.
REQ-033 After reset deasserts, the first rising edge SHALL obey normal rules.

Verification
REQ-034 Scan-and-arm: shift 20 bits {1, 19'h5A5A5}, then update (SETTLE=2) -> ijtag_data_out=19'h5A5A5 at the update edge, ijtag_select=0 at update+1 and 1 at update+2.
REQ-035 Capture readback: functional_data_in=19'h7FFFF with ijtag_select=1; capture, then shift 20 -> so stream LSB-first is nineteen 1s then 1.
REQ-036 Abort: update req=1, then at update+1 update req=0 -> ijtag_select stays 0 throughout; state is IDLE.
REQ-037 Live data change: in ACTIVE, update {1, 19'h00001} -> ijtag_data_out=19'h00001 next edge; ijtag_select stays 1 with no gap.
REQ-038 Release: in ACTIVE, update {0, 19'h12345} -> ijtag_select=0 and ijtag_data_out=19'h12345 on the same edge.
REQ-039 Async reset mid-SETTLING (cnt=1): pulse ijtag_reset low between edges -> ijtag_select, ijtag_data_out and SR are 0 immediately; no later select assertion.
